// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with registered grant.
//
// One requester at a time is granted. The grant is held until the consumer
// acks, the arbiter is disabled, or the granted requester drops its request.
// At least one empty (all-zero) grant cycle separates consecutive grants.
// The search for the next winner starts just after the last winner, so every
// active requester is served in turn.
//
// Optional feature, macro RR_ARBITER4_TIMEOUT_EN:
//   When defined, a grant is forcibly ended after MAX_HOLD cycles and
//   'timeout' pulses for one cycle. When undefined, grants have no time
//   limit and 'timeout' is held at 0.
//
// Parameters:
//   MAX_HOLD   cycles a grant may be held when the timeout is built in (1..255)
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  enable; low blocks new grants and ends the current one
//   req        in   4  request lines, bit i = requester i
//   ack        in   1  consumer done; ends the current grant
//   grant      out  4  registered grant, one-hot or zero
//   valid      out  1  registered, high exactly when grant is non-zero
//   timeout    out  1  registered one-cycle pulse when a grant is forced off
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no grant; choose a winner from the sampled requests
// ST_BUSY | grant held; watch for ack, en low, request drop or hold expiry

module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_gidx;
    logic [1:0] w_gidx_nxt;

    logic       w_pick_found;
    logic [1:0] w_pick_idx;
    logic       w_rel_cause;
    logic       w_hold_expire;

    // Rotating priority search: ptr+1 first, ptr itself last. The 2-bit
    // addition wraps naturally, so k=4 lands back on ptr.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!w_pick_found && req[r_ptr + 2'(k)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = r_ptr + 2'(k);
            end
        end
    end

    // Any of these ends the grant; the timeout only counts as the cause
    // when none of them is present.
    assign w_rel_cause = ack | ~en | ~req[r_gidx];

`ifdef RR_ARBITER4_TIMEOUT_EN
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;

    // Counter reads 0 in the first BUSY cycle, so reaching MAX_HOLD-1 here
    // means this edge would make it MAX_HOLD: the grant has had its cycles.
    assign w_hold_expire = (r_state == ST_BUSY) && (r_hold == 8'(MAX_HOLD - 1));

    always_comb begin
        w_hold_nxt = 8'd0;
        if (r_state == ST_BUSY && w_state_nxt == ST_BUSY) begin
            w_hold_nxt = r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`else
    assign w_hold_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_gidx_nxt    = r_gidx;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 4'b0000;
                w_valid_nxt = 1'b0;
                if (en && w_pick_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = 4'b0001 << w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_gidx_nxt  = w_pick_idx;
                end
            end

            ST_BUSY: begin
                if (w_rel_cause || w_hold_expire) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_gidx;
                    w_timeout_nxt = ~w_rel_cause;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 4'b0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'd3;
            r_gidx    <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
        end
    end

    assign grant   = r_grant;
    assign valid   = r_valid;
    assign timeout = r_timeout;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
    a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n) r_valid == (|r_grant));

endmodule
